// File: rtl/micro_ondas_pkg.sv
// Shared types and constants for the microwave oven controller.
package micro_ondas_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] MAX_POWER = 4'd10;
  localparam logic [9:0] KEY_NONE  = 10'd0;

  // Index of the set bit of a one-hot keypad vector.
  function automatic logic [3:0] key_value(input logic [9:0] keys);
    logic [3:0] v;
    v = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (keys[i]) v = 4'(i);
    end
    return v;
  endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// NDIG-digit BCD time register: clear, shift-in of a new digit, and a
// one-second decrement where seconds-tens wraps to 5 and all others to 9.
module bcd_down_counter #(
  parameter int NDIG = 4
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                clr,
  input  logic                shift,
  input  logic [3:0]          shift_digit,
  input  logic                dec,
  output logic [4*NDIG-1:0]   value,
  output logic                zero,
  output logic                one
);

  logic [4*NDIG-1:0] digits_reg;
  logic [4*NDIG-1:0] digits_next;
  logic [4*NDIG-1:0] dec_value;
  logic [NDIG-1:0]   borrow;

  assign borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      localparam logic [3:0] WRAP = (gi == 1) ? 4'd5 : 4'd9;
      logic [3:0] d;
      assign d = digits_reg[4*gi +: 4];
      assign dec_value[4*gi +: 4] = !borrow[gi] ? d :
                                    (d == 4'd0) ? WRAP : d - 4'd1;
      if (gi < NDIG - 1) begin : g_borrow
        assign borrow[gi+1] = borrow[gi] & (d == 4'd0);
      end
    end
  endgenerate

  always_comb begin
    digits_next = digits_reg;
    if (clr)
      digits_next = '0;
    else if (shift)
      digits_next = {digits_reg[4*NDIG-5:0], shift_digit};
    else if (dec)
      digits_next = dec_value;
  end

  always_ff @(posedge clock) begin
    if (!resetn)
      digits_reg <= '0;
    else
      digits_reg <= digits_next;
  end

  assign value = digits_reg;
  assign zero  = (digits_reg == '0);
  assign one   = (digits_reg == (4*NDIG)'(1));

endmodule

// File: rtl/micro_ondas_ctrl.sv
// Microwave oven controller: keypad time entry, BCD countdown with pause,
// door interlock and magnetron duty cycling over a POWER_PERIOD window.
module micro_ondas_ctrl #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int NDIG         = 4,
  parameter int POWER_PERIOD = 10
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [9:0]        keypad,
  input  logic              startn,
  input  logic              stopn,
  input  logic              clearn,
  input  logic              door_closed,
  input  logic [3:0]        power_level,
  output logic [4*NDIG-1:0] digits,
  output logic              mag_on,
  output logic [1:0]        state,
  output logic              done
);
  import micro_ondas_pkg::*;

  localparam int PW  = $clog2(CLK_HZ);
  localparam int PHW = (POWER_PERIOD > 1) ? $clog2(POWER_PERIOD) : 1;
  localparam logic [PW-1:0]  PRE_MAX   = PW'(CLK_HZ - 1);
  localparam logic [PHW-1:0] PHASE_MAX = PHW'(POWER_PERIOD - 1);

  state_t         state_reg, state_next;
  logic [PW-1:0]  pre_reg, pre_next;
  logic [PHW-1:0] phase_reg, phase_next;
  logic [3:0]     power_reg, power_next;
  logic           startn_reg, stopn_reg, clearn_reg;
  logic [9:0]     key_reg;

  logic start_press, stop_press, clear_press, key_press;
  logic cnt_clr, cnt_shift, tick, cnt_zero, cnt_one;

  assign start_press = !startn && startn_reg;
  assign stop_press  = !stopn && stopn_reg;
  assign clear_press = !clearn && clearn_reg;
  assign key_press   = $onehot(keypad) && (key_reg == KEY_NONE);

  always_comb begin
    state_next = state_reg;
    pre_next   = pre_reg;
    phase_next = phase_reg;
    power_next = power_reg;
    cnt_clr    = 1'b0;
    cnt_shift  = 1'b0;
    tick       = 1'b0;
    if (clear_press) begin
      state_next = IDLE;
      cnt_clr    = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (stop_press) begin
            cnt_clr = 1'b1;
          end else if (start_press) begin
            if (door_closed && !cnt_zero) begin
              state_next = COOK;
              pre_next   = '0;
              phase_next = '0;
              power_next = (power_level == 4'd0 || power_level > MAX_POWER) ?
                           MAX_POWER : power_level;
            end
          end else if (key_press) begin
            cnt_shift = 1'b1;
          end
        end
        COOK: begin
          // Opening the door or stopping freezes the prescaler mid-second.
          if (!door_closed || stop_press) begin
            state_next = PAUSE;
          end else begin
            tick     = (pre_reg == PRE_MAX);
            pre_next = tick ? '0 : pre_reg + 1'b1;
            if (tick) begin
              phase_next = (phase_reg == PHASE_MAX) ? '0 : phase_reg + 1'b1;
              if (cnt_one) state_next = DONE;
            end
          end
        end
        PAUSE: begin
          if (stop_press) begin
            state_next = IDLE;
            cnt_clr    = 1'b1;
          end else if (start_press && door_closed) begin
            state_next = COOK;
          end
        end
        DONE: begin
          if (key_press || stop_press || !door_closed) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      pre_reg    <= '0;
      phase_reg  <= '0;
      power_reg  <= MAX_POWER;
      startn_reg <= 1'b1;
      stopn_reg  <= 1'b1;
      clearn_reg <= 1'b1;
      key_reg    <= KEY_NONE;
    end else begin
      state_reg  <= state_next;
      pre_reg    <= pre_next;
      phase_reg  <= phase_next;
      power_reg  <= power_next;
      startn_reg <= startn;
      stopn_reg  <= stopn;
      clearn_reg <= clearn;
      key_reg    <= keypad;
    end
  end

  bcd_down_counter #(.NDIG(NDIG)) u_counter (
    .clock       (clock),
    .resetn      (resetn),
    .clr         (cnt_clr),
    .shift       (cnt_shift),
    .shift_digit (key_value(keypad)),
    .dec         (tick),
    .value       (digits),
    .zero        (cnt_zero),
    .one         (cnt_one)
  );

  assign mag_on = (state_reg == COOK) && door_closed &&
                  (32'(phase_reg) < 32'(power_reg));
  assign state  = state_reg;
  assign done   = (state_reg == DONE);

endmodule
